network_host: RTL



---
 rtl/network_host.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/network_host.sv
// network_host: host-side initiator for the stochastic-bitstream network
// controller. It takes one operand set per request and pulses start for one
// cycle. It then waits for finish, with a timeout guard, and returns the
// captured result words on a valid/ready response port.
//
// Ports:
//   clk, n_rst          clock (rising edge), async active-low reset
//   req_valid/ready     request handshake; req_data = INPUT_SIZE operand words
//   ctrl_to_net         bit0 = start (high only in START), bits7:1 = 0
//   ctrl_from_net       bit0 = finish, bits7:6 = controller state (status only)
//   net_data_in         held operand words driven to the network
//   net_data_out        network result words
//   rsp_valid/ready     response handshake; rsp_data = OUTPUT_SIZE words
//   rsp_timeout         1 = transaction aborted, rsp_data forced to 0
//   busy                state != IDLE
//   proto_err           sticky, finish observed outside WAIT
//   done_count          completed (non-timeout) transactions, wraps

// One result word: loaded on finish, cleared on timeout, held otherwise.
module network_host_rsp_lane (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_load,
  input  logic        i_clr,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);
  logic [31:0] r_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      r_q <= '0;
    else if (i_load) r_q <= i_d;
    else if (i_clr)  r_q <= '0;
  end

  assign o_q = r_q;
endmodule

module network_host #(
  parameter int INPUT_SIZE  = 2,
  parameter int OUTPUT_SIZE = 1,
  parameter int TIMEOUT     = 512
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [INPUT_SIZE-1:0][31:0]  req_data,
  output logic [7:0]                   ctrl_to_net,
  input  logic [7:0]                   ctrl_from_net,
  output logic [INPUT_SIZE-1:0][31:0]  net_data_in,
  input  logic [OUTPUT_SIZE-1:0][31:0] net_data_out,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [OUTPUT_SIZE-1:0][31:0] rsp_data,
  output logic                         rsp_timeout,
  output logic                         busy,
  output logic                         proto_err,
  output logic [15:0]                  done_count
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t                        r_state;
  logic [INPUT_SIZE-1:0][31:0]   r_opnd;
  logic [15:0]                   r_timer;
  logic                          r_rsp_valid;
  logic                          r_rsp_to;
  logic                          r_perr;
  logic [15:0]                   r_done;

  logic w_fin;
  logic w_tmo_hit;
  logic w_load;
  logic w_clr;
  // Controller status bits are informational; nothing here reacts to them.
  logic w_unused;

  assign w_fin     = ctrl_from_net[0];
  assign w_unused  = ^ctrl_from_net[7:1];
  assign w_tmo_hit = (r_timer == 16'(TIMEOUT - 1));
  // Finish takes priority over the timeout terminal count.
  assign w_load    = (r_state == S_WAIT) && w_fin;
  assign w_clr     = (r_state == S_WAIT) && !w_fin && w_tmo_hit;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_opnd      <= '0;
      r_timer     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_to    <= 1'b0;
      r_perr      <= 1'b0;
      r_done      <= '0;
    end else begin
      if (w_fin && (r_state != S_WAIT)) r_perr <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_opnd  <= req_data;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_timer <= r_timer + 16'd1;
          if (w_fin) begin
            r_rsp_to    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_done      <= r_done + 16'd1;
            r_state     <= S_RESP;
          end else if (w_tmo_hit) begin
            r_rsp_to    <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < OUTPUT_SIZE; g++) begin : g_lane
    network_host_rsp_lane u_lane (
      .clk    (clk),
      .n_rst  (n_rst),
      .i_load (w_load),
      .i_clr  (w_clr),
      .i_d    (net_data_out[g]),
      .o_q    (rsp_data[g])
    );
  end

  assign req_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign ctrl_to_net = {7'b0, (r_state == S_START)};
  assign net_data_in = r_opnd;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_timeout = r_rsp_to;
  assign proto_err   = r_perr;
  assign done_count  = r_done;
endmodule
